// File: rtl/cell_chain_walker.sv
// Walks a packet's cell linked list through the pointer memory, hands each
// cell pointer downstream, then returns the whole chain to the free queue.
`timescale 1ns/1ps
module cell_chain_walker #(
  parameter int PTR_W  = 10,
  parameter int CNT_W  = 6,
  parameter int RD_LAT = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pkt_req_valid,
  output logic             pkt_req_ready,
  input  logic [PTR_W-1:0] pkt_head_ptr,
  input  logic [CNT_W-1:0] pkt_cell_cnt,
  output logic             cell_mem_rd,
  output logic [15:0]      cell_mem_addr,
  input  logic [31:0]      cell_mem_dout,
  output logic             cell_ptr_valid,
  input  logic             cell_ptr_ready,
  output logic [PTR_W-1:0] cell_ptr,
  output logic             cell_ptr_last,
  output logic             FQ_wr,
  output logic [15:0]      FQ_din_head,
  output logic [15:0]      FQ_din_tail,
  output logic             busy,
  output logic             ptr_err,
  output logic             zero_cnt_err
);

  localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {IDLE, EMIT, RD_ISSUE, RD_WAIT, RET, GAP} state_t;

  state_t           state, state_nx;
  logic [PTR_W-1:0] cur_ptr, cur_ptr_nx;
  logic [PTR_W-1:0] first_ptr, first_ptr_nx;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_nx;

  logic             pkt_req_ready_nx, cell_mem_rd_nx, cell_ptr_valid_nx;
  logic [15:0]      cell_mem_addr_nx, fq_head_nx, fq_tail_nx;
  logic [PTR_W-1:0] cell_ptr_nx;
  logic             cell_ptr_last_nx, fq_wr_nx, busy_nx;
  logic             ptr_err_nx, zero_cnt_err_nx;

  always_comb begin
    state_nx        = state;
    cur_ptr_nx      = cur_ptr;
    first_ptr_nx    = first_ptr;
    remaining_nx    = remaining;
    wait_cnt_nx     = wait_cnt;
    ptr_err_nx      = ptr_err;
    zero_cnt_err_nx = zero_cnt_err;

    case (state)
      IDLE: begin
        if (pkt_req_valid) begin
          if (pkt_cell_cnt == '0) begin
            zero_cnt_err_nx = 1'b1;
          end else begin
            first_ptr_nx = pkt_head_ptr;
            cur_ptr_nx   = pkt_head_ptr;
            remaining_nx = pkt_cell_cnt;
            state_nx     = EMIT;
          end
        end
      end
      EMIT: begin
        if (cell_ptr_ready) begin
          if (remaining == CNT_W'(1)) begin
            state_nx = RET;
          end else begin
            remaining_nx = remaining - 1'b1;
            state_nx     = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        wait_cnt_nx = '0;
        state_nx    = RD_WAIT;
      end
      RD_WAIT: begin
        wait_cnt_nx = wait_cnt + 1'b1;
        if (wait_cnt == WC_W'(RD_LAT - 1)) begin
          cur_ptr_nx = PTR_W'(cell_mem_dout[24:16]);
          if (cell_mem_dout[8:0] != cell_mem_addr[8:0]) ptr_err_nx = 1'b1;
          state_nx = EMIT;
        end
      end
      RET:     state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Outputs are registered copies decoded from the next state, so each
    // output changes on the same edge that the state does.
    pkt_req_ready_nx  = (state_nx == IDLE);
    busy_nx           = (state_nx != IDLE);
    cell_ptr_valid_nx = (state_nx == EMIT);
    cell_mem_rd_nx    = (state_nx == RD_ISSUE);
    fq_wr_nx          = (state_nx == RET);

    cell_ptr_nx      = cell_ptr;
    cell_ptr_last_nx = cell_ptr_last;
    if (state_nx == EMIT) begin
      cell_ptr_nx      = cur_ptr_nx;
      cell_ptr_last_nx = (remaining_nx == CNT_W'(1));
    end

    cell_mem_addr_nx = cell_mem_addr;
    if (state_nx == RD_ISSUE) cell_mem_addr_nx = 16'(cur_ptr_nx);

    fq_head_nx = FQ_din_head;
    fq_tail_nx = FQ_din_tail;
    if (state_nx == RET) begin
      fq_head_nx = 16'(first_ptr_nx);
      fq_tail_nx = 16'(cur_ptr_nx);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cur_ptr        <= '0;
      first_ptr      <= '0;
      remaining      <= '0;
      wait_cnt       <= '0;
      pkt_req_ready  <= 1'b1;
      busy           <= 1'b0;
      cell_ptr_valid <= 1'b0;
      cell_ptr       <= '0;
      cell_ptr_last  <= 1'b0;
      cell_mem_rd    <= 1'b0;
      cell_mem_addr  <= '0;
      FQ_wr          <= 1'b0;
      FQ_din_head    <= '0;
      FQ_din_tail    <= '0;
      ptr_err        <= 1'b0;
      zero_cnt_err   <= 1'b0;
    end else begin
      state          <= state_nx;
      cur_ptr        <= cur_ptr_nx;
      first_ptr      <= first_ptr_nx;
      remaining      <= remaining_nx;
      wait_cnt       <= wait_cnt_nx;
      pkt_req_ready  <= pkt_req_ready_nx;
      busy           <= busy_nx;
      cell_ptr_valid <= cell_ptr_valid_nx;
      cell_ptr       <= cell_ptr_nx;
      cell_ptr_last  <= cell_ptr_last_nx;
      cell_mem_rd    <= cell_mem_rd_nx;
      cell_mem_addr  <= cell_mem_addr_nx;
      FQ_wr          <= fq_wr_nx;
      FQ_din_head    <= fq_head_nx;
      FQ_din_tail    <= fq_tail_nx;
      ptr_err        <= ptr_err_nx;
      zero_cnt_err   <= zero_cnt_err_nx;
    end
  end

endmodule
